// File: rtl/vga_span_fill_if.sv
// vga_span_fill_if: bundles the span-fill command handshake and the SRAM
// write-port request/grant signals of vga_span_fill.
//   slave  modport: the span-fill block (consumes commands, drives SRAM writes)
//   master modport: the processor / arbiter side
// Optional macro SPAN_FILL_GRADIENT_EN adds the cmd_step field.
interface vga_span_fill_if #(
  parameter int PIX_W = 10
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [PIX_W-1:0] cmd_x;
  logic [PIX_W:0]   cmd_len;
  logic [15:0]      cmd_color;
`ifdef SPAN_FILL_GRADIENT_EN
  logic [15:0]      cmd_step;
`endif
  logic             abort;
  logic             sram_wr_en;
  logic [15:0]      sram_wr_addr;
  logic [15:0]      sram_wr_data;
  logic             sram_wr_ready;

  modport slave (
`ifdef SPAN_FILL_GRADIENT_EN
    input  cmd_step,
`endif
    input  cmd_valid, cmd_x, cmd_len, cmd_color, abort, sram_wr_ready,
    output cmd_ready, sram_wr_en, sram_wr_addr, sram_wr_data
  );

  modport master (
`ifdef SPAN_FILL_GRADIENT_EN
    output cmd_step,
`endif
    output cmd_valid, cmd_x, cmd_len, cmd_color, abort, sram_wr_ready,
    input  cmd_ready, sram_wr_en, sram_wr_addr, sram_wr_data
  );
endinterface

// File: rtl/vga_span_fill.sv
// vga_span_fill: writes horizontal spans of RGB565 pixels into the scanline
// buffer in SRAM, one 16-bit word per granted cycle.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   bus       - vga_span_fill_if.slave: command handshake (cmd_valid/ready,
//               cmd_x, cmd_len, cmd_color[, cmd_step]), abort, and the SRAM
//               write port (sram_wr_en/addr/data, sram_wr_ready grant)
//   busy      - high while a span is being written
//   done      - one-cycle pulse when a span finishes normally
//   pix_count - writes completed for the current or last span
// Macro SPAN_FILL_GRADIENT_EN: when defined, each granted write advances the
// colour by a per-field wrapping step (cmd_step); otherwise spans are solid.
module vga_span_fill #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          LINE_PIXELS = 1024,
  parameter int          PIX_W       = 10
) (
  input  logic           clk,
  input  logic           rst,
  vga_span_fill_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic [PIX_W:0] pix_count
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [PIX_W:0] MAX_LEN = (PIX_W+1)'(LINE_PIXELS);
  localparam logic [PIX_W:0] ONE_LEN = {{PIX_W{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [PIX_W-1:0] cur_x_q, cur_x_d;
  logic [PIX_W:0]   rem_q, rem_d;
  logic [PIX_W:0]   pix_q, pix_d;
  logic [15:0]      data_q, data_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             grant;
  logic [PIX_W:0]   len_clamped;

`ifdef SPAN_FILL_GRADIENT_EN
  logic [15:0]      step_q, step_d;

  // Independent modular add per colour field; no carry crosses R/G/B.
  function automatic logic [15:0] grad_add(input logic [15:0] c,
                                           input logic [15:0] s);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = c[15:11] + s[15:11];
    g = c[10:5]  + s[10:5];
    b = c[4:0]   + s[4:0];
    return {r, g, b};
  endfunction
`endif

  assign grant       = en_q && bus.sram_wr_ready;
  assign len_clamped = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    rem_d   = rem_q;
    pix_d   = pix_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef SPAN_FILL_GRADIENT_EN
    step_d  = step_q;
`endif
    case (state_q)
      IDLE: begin
        // abort is deliberately not consulted here: commands are accepted regardless.
        if (bus.cmd_valid && ready_q) begin
          cur_x_d = bus.cmd_x;
          rem_d   = len_clamped;
          data_d  = bus.cmd_color;
          pix_d   = '0;
`ifdef SPAN_FILL_GRADIENT_EN
          step_d  = bus.cmd_step;
`endif
          if (len_clamped == '0) done_d  = 1'b1;
          else                   state_d = FILL;
        end
      end
      FILL: begin
        // A grant in the abort cycle still counts: the arbiter has taken the word.
        if (grant) begin
          cur_x_d = cur_x_q + 1'b1;  // wraps at LINE_PIXELS (power of two)
          pix_d   = pix_q + 1'b1;
          rem_d   = rem_q - 1'b1;
`ifdef SPAN_FILL_GRADIENT_EN
          data_d  = grad_add(data_q, step_q);
`endif
        end
        if (bus.abort) begin
          state_d = IDLE;
        end else if (grant && (rem_q == ONE_LEN)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered so they follow the state one edge later.
    ready_d = (state_d == IDLE);
    en_d    = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      rem_q   <= '0;
      pix_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
`ifdef SPAN_FILL_GRADIENT_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      rem_q   <= rem_d;
      pix_q   <= pix_d;
      data_q  <= data_d;
      done_q  <= done_d;
      en_q    <= en_d;
      ready_q <= ready_d;
`ifdef SPAN_FILL_GRADIENT_EN
      step_q  <= step_d;
`endif
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.sram_wr_en   = en_q;
  assign bus.sram_wr_addr = BASE_ADDR + {{(15-PIX_W){1'b0}}, cur_x_q, 1'b0};
  assign bus.sram_wr_data = data_q;
  assign busy             = (state_q == FILL);
  assign done             = done_q;
  assign pix_count        = pix_q;

endmodule

// File: tb/tb_vga_span_fill.sv
// tb_vga_span_fill: directed bench for vga_span_fill. The driver pushes the
// expected SRAM writes and done pulses into queues as commands are issued;
// a monitor on the falling edge pops and compares on every granted write and
// every done pulse.
module tb_vga_span_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic        done;
  logic [10:0] pix_count;

  vga_span_fill_if #(.PIX_W(10)) bus ();

  vga_span_fill #(
    .BASE_ADDR  (16'h0000),
    .LINE_PIXELS(1024),
    .PIX_W      (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int pix;
    int cyc;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: scoreboard comparison of every granted write and done pulse.
  always @(negedge clk) begin : monitor
    wr_t e;
    dn_t d;
    if (bus.sram_wr_en && bus.sram_wr_ready) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", int'(bus.sram_wr_addr), -1);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", int'(bus.sram_wr_addr), int'(e.addr));
        chk("wr_data", int'(bus.sram_wr_data), int'(e.data));
        if (e.cyc >= 0) chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", int'(pix_count), -1);
      end else begin
        d = dq.pop_front();
        chk("done_pix_count", int'(pix_count), d.pix);
        chk("done_cycle", cyc, d.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_solid(int x, int len, logic [15:0] color, int c0);
    for (int i = 0; i < len; i++) begin
      wr_t e;
      e.addr = 16'(((x + i) % 1024) * 2);
      e.data = color;
      e.cyc  = (c0 < 0) ? -1 : c0 + i;
      wq.push_back(e);
    end
  endtask

  task automatic push_wr(logic [15:0] addr, logic [15:0] data, int c);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = c;
    wq.push_back(e);
  endtask

  task automatic push_done(int pix, int c);
    dn_t d;
    d.pix = pix;
    d.cyc = c;
    dq.push_back(d);
  endtask

  // Presents one command for exactly one cycle.
  task automatic send(int x, int len, logic [15:0] color, logic [15:0] step);
    chk("cmd_ready_at_issue", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_x     = 10'(x);
    bus.cmd_len   = 11'(len);
    bus.cmd_color = color;
`ifdef SPAN_FILL_GRADIENT_EN
    bus.cmd_step  = step;
`else
    if (step != 16'h0) $display("note: step ignored in solid build");
`endif
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_cmd_ready"}, int'(bus.cmd_ready), 0);
    chk({tag, "_wr_en"},     int'(bus.sram_wr_en), 0);
    chk({tag, "_wr_addr"},   int'(bus.sram_wr_addr), 0);
    chk({tag, "_wr_data"},   int'(bus.sram_wr_data), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_pix_count"}, int'(pix_count), 0);
  endtask

  initial begin
    int n;
    bus.cmd_valid     = 1'b0;
    bus.cmd_x         = '0;
    bus.cmd_len       = '0;
    bus.cmd_color     = '0;
`ifdef SPAN_FILL_GRADIENT_EN
    bus.cmd_step      = '0;
`endif
    bus.abort         = 1'b0;
    bus.sram_wr_ready = 1'b1;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    chk("ready_after_reset", int'(bus.cmd_ready), 1);

    // Basic span: x=0 len=4 red, writes N+1..N+4, done at N+5
    n = cyc;
    push_solid(0, 4, 16'hF800, n + 1);
    push_done(4, n + 5);
    send(0, 4, 16'hF800, 16'h0);
    repeat (6) tick();
    chk("basic_pix_count", int'(pix_count), 4);
    chk("basic_busy_after", int'(busy), 0);

    // Wrap around the end of the line
    n = cyc;
    push_solid(1022, 4, 16'h07E0, n + 1);
    push_done(4, n + 5);
    send(1022, 4, 16'h07E0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_busy", int'(busy), 1);
      tick();
    end
    chk("wrap_busy_end", int'(busy), 0);
    repeat (2) tick();

    // Stall: grant pattern 1,0,0,1,1
    n = cyc;
    push_wr(16'h0014, 16'h001F, n + 1);
    push_wr(16'h0016, 16'h001F, n + 4);
    push_wr(16'h0018, 16'h001F, n + 5);
    push_done(3, n + 6);
    send(10, 3, 16'h001F, 16'h0);
    tick();
    bus.sram_wr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stall_wr_en", int'(bus.sram_wr_en), 1);
      chk("stall_addr_held", int'(bus.sram_wr_addr), 16'h0016);
      chk("stall_data_held", int'(bus.sram_wr_data), 16'h001F);
      tick();
    end
    bus.sram_wr_ready = 1'b1;
    repeat (4) tick();

    // Zero length: no write, done next cycle with pix_count 0
    n = cyc;
    push_done(0, n + 1);
    send(5, 0, 16'h1234, 16'h0);
    chk("len0_no_wr_en", int'(bus.sram_wr_en), 0);
    repeat (2) tick();

    // Oversize length clamps to one full line
    n = cyc;
    push_solid(0, 1024, 16'h1234, -1);
    push_done(1024, n + 1025);
    send(0, 2047, 16'h1234, 16'h0);
    repeat (1026) tick();
    chk("clamp_pix_count", int'(pix_count), 1024);

    // Abort after two writes (second grant shares the abort cycle)
    n = cyc;
    push_solid(100, 2, 16'hABCD, n + 1);
    send(100, 8, 16'hABCD, 16'h0);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_wr_en", int'(bus.sram_wr_en), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pix_count", int'(pix_count), 2);
    chk("abort_busy", int'(busy), 0);

    // Command presented together with abort in IDLE is still accepted
    n = cyc;
    push_solid(0, 1, 16'h5555, n + 1);
    push_done(1, n + 2);
    bus.abort = 1'b1;
    send(0, 1, 16'h5555, 16'h0);
    bus.abort = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a span
    n = cyc;
    push_solid(200, 1, 16'h0F0F, n + 1);
    send(200, 8, 16'h0F0F, 16'h0);
    tick();
    rst = 1'b1;
    bus.sram_wr_ready = 1'b0;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
    bus.sram_wr_ready = 1'b1;
    tick();
    chk("ready_after_midrst", int'(bus.cmd_ready), 1);

`ifdef SPAN_FILL_GRADIENT_EN
    // Gradient: 0x0000 + 0x0821 per pixel
    n = cyc;
    push_wr(16'h0000, 16'h0000, n + 1);
    push_wr(16'h0002, 16'h0821, n + 2);
    push_wr(16'h0004, 16'h1042, n + 3);
    push_done(3, n + 4);
    send(0, 3, 16'h0000, 16'h0821);
    repeat (5) tick();

    // Blue field wraps without carrying into green
    n = cyc;
    push_wr(16'h0000, 16'h001F, n + 1);
    push_wr(16'h0002, 16'h0000, n + 2);
    push_done(2, n + 3);
    send(0, 2, 16'h001F, 16'h0001);
    repeat (4) tick();
`endif

    chk("writes_all_seen", wq.size(), 0);
    chk("dones_all_seen", dq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
